// File: rtl/traffic_pkg.sv
// Shared types and light encodings for the phased traffic controller.
// The FLASH state exists only when TRAFFIC_NIGHT_FLASH_EN is defined.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_GREEN     = 3'd1,
    ST_YELLOW    = 3'd2,
    ST_ALLRED    = 3'd3,
    ST_WALK      = 3'd4,
    ST_WALKFLASH = 3'd5
`ifdef TRAFFIC_NIGHT_FLASH_EN
    , ST_FLASH   = 3'd6
`endif
  } state_e;

  // Vehicle lamp encodings {red,yellow,green}
  localparam logic [2:0] RED       = 3'b100;
  localparam logic [2:0] YELLOW    = 3'b010;
  localparam logic [2:0] GREEN     = 3'b001;
  localparam logic [2:0] LAMP_OFF  = 3'b000;

  // Pedestrian lamp encodings {red,green}
  localparam logic [1:0] PEA_RED   = 2'b10;
  localparam logic [1:0] PEA_GREEN = 2'b01;
  localparam logic [1:0] PEA_OFF   = 2'b00;

  // Larger of two integers, used to size the seconds counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phased_traffic_ctrl_chk.sv
// Safety invariants on the light outputs: at most one vehicle phase
// showing yellow or green, and no vehicle green while pedestrians see green.
module phased_traffic_ctrl_chk #(
  parameter int N_PHASES = 3
) (
  input logic                  clk,
  input logic                  nreset,
  input logic [3*N_PHASES-1:0] phase_lights,
  input logic [1:0]            pea_lights
);

  function automatic int lit_count(input logic [3*N_PHASES-1:0] pl);
    int n;
    n = 0;
    for (int i = 0; i < N_PHASES; i++) begin
      if (pl[3*i+1] || pl[3*i]) begin
        n = n + 1;
      end else begin
        n = n + 0;
      end
    end
    return n;
  endfunction

  function automatic logic any_green(input logic [3*N_PHASES-1:0] pl);
    logic g;
    g = 1'b0;
    for (int i = 0; i < N_PHASES; i++) begin
      g = g | pl[3*i];
    end
    return g;
  endfunction

  // Evaluate the invariants on every clock edge while out of reset.
  always @(posedge clk) begin
    if (nreset) begin
      assert (lit_count(phase_lights) <= 1);
      assert (!(pea_lights[0] && any_green(phase_lights)));
    end else begin
    end
  end

endmodule

// File: rtl/phased_traffic_ctrl_tick_gen.sv
// One-second tick and half-second flag derived from the system clock.
module tick_gen #(
  parameter int FPGAFREQ = 50_000_000
) (
  input  logic i_clk,
  input  logic i_nreset,
  output logic o_tick,
  output logic o_half
);

  localparam int CW = (FPGAFREQ > 1) ? $clog2(FPGAFREQ) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(FPGAFREQ - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(FPGAFREQ / 2);

  logic [CW-1:0] r_cnt;

  // Free-running divider that wraps once per second.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST_CNT) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST_CNT);
  assign o_half = (r_cnt < HALF_CNT);

endmodule

// File: rtl/phased_traffic_ctrl.sv
// Multi-phase traffic light controller with pedestrian request.
// Optional night flashing mode enabled by macro TRAFFIC_NIGHT_FLASH_EN
// (adds the night input and the FLASH state).
module phased_traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int FPGAFREQ    = 50_000_000,
  parameter int N_PHASES    = 3,
  parameter int T_GREENMAIN = 18,
  parameter int T_GREENSEC  = 10,
  parameter int T_YELLOW    = 4,
  parameter int T_ALLRED    = 1,
  parameter int T_WALK      = 5,
  parameter int T_WALKFLASH = 3,
  parameter int T_RESET     = 3,
  localparam int T_MAX = max_int(max_int(max_int(T_GREENMAIN, T_GREENSEC),
                                         max_int(T_YELLOW, T_ALLRED)),
                                 max_int(max_int(T_WALK, T_WALKFLASH), T_RESET)),
  localparam int SECW = $clog2(T_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  b_npeaton,
`ifdef TRAFFIC_NIGHT_FLASH_EN
  input  logic                  night,
`endif
  output logic [3*N_PHASES-1:0] phase_lights,
  output logic [1:0]            pea_lights,
  output logic                  sol_light,
  output logic [SECW-1:0]       sec_left
);

  localparam int PW = $clog2(N_PHASES);
  localparam logic [PW-1:0]   LAST_PHASE  = PW'(N_PHASES - 1);
  localparam logic [SECW-1:0] L_GREENMAIN = SECW'(T_GREENMAIN - 1);
  localparam logic [SECW-1:0] L_GREENSEC  = SECW'(T_GREENSEC - 1);
  localparam logic [SECW-1:0] L_YELLOW    = SECW'(T_YELLOW - 1);
  localparam logic [SECW-1:0] L_ALLRED    = SECW'(T_ALLRED - 1);
  localparam logic [SECW-1:0] L_WALK      = SECW'(T_WALK - 1);
  localparam logic [SECW-1:0] L_WALKFLASH = SECW'(T_WALKFLASH - 1);
  localparam logic [SECW-1:0] L_RESET     = SECW'(T_RESET - 1);

  state_e          r_state, w_state_nxt;
  logic [PW-1:0]   r_phase, w_phase_nxt;
  logic [SECW-1:0] r_sec, w_sec_nxt;
  logic            r_sync1, r_sync2;
  logic            r_req, w_req_nxt;
  logic            w_walk_go;
  logic            w_tick, w_half;

  tick_gen #(.FPGAFREQ(FPGAFREQ)) u_tick (
    .i_clk    (clk),
    .i_nreset (nreset),
    .o_tick   (w_tick),
    .o_half   (w_half)
  );

  phased_traffic_ctrl_chk #(.N_PHASES(N_PHASES)) u_chk (
    .clk          (clk),
    .nreset       (nreset),
    .phase_lights (phase_lights),
    .pea_lights   (pea_lights)
  );

  // State, phase, timer, request and button synchroniser registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_RESET;
      r_phase <= '0;
      r_sec   <= L_RESET;
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_sec   <= w_sec_nxt;
      r_sync1 <= b_npeaton;
      r_sync2 <= r_sync1;
      r_req   <= w_req_nxt;
    end
  end

  // Next-state logic: count down on ticks, advance on time-up.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_sec_nxt   = r_sec;
    w_walk_go   = 1'b0;
    if (w_tick) begin
      if (r_sec != '0) begin
        w_sec_nxt = r_sec - SECW'(1);
      end
`ifdef TRAFFIC_NIGHT_FLASH_EN
      else if (night) begin
        w_state_nxt = ST_FLASH;
        w_phase_nxt = '0;
        w_sec_nxt   = '0;
      end
`endif
      else begin
        case (r_state)
          ST_RESET: begin
            w_state_nxt = ST_GREEN;
            w_phase_nxt = '0;
            w_sec_nxt   = L_GREENMAIN;
          end
          ST_GREEN: begin
            w_state_nxt = ST_YELLOW;
            w_sec_nxt   = L_YELLOW;
          end
          ST_YELLOW: begin
            w_state_nxt = ST_ALLRED;
            w_sec_nxt   = L_ALLRED;
          end
          ST_ALLRED: begin
            if (r_phase != LAST_PHASE) begin
              w_state_nxt = ST_GREEN;
              w_phase_nxt = r_phase + PW'(1);
              w_sec_nxt   = L_GREENSEC;
            end else if (r_req) begin
              w_state_nxt = ST_WALK;
              w_sec_nxt   = L_WALK;
              w_walk_go   = 1'b1;
            end else begin
              w_state_nxt = ST_GREEN;
              w_phase_nxt = '0;
              w_sec_nxt   = L_GREENMAIN;
            end
          end
          ST_WALK: begin
            w_state_nxt = ST_WALKFLASH;
            w_sec_nxt   = L_WALKFLASH;
          end
          ST_WALKFLASH: begin
            w_state_nxt = ST_GREEN;
            w_phase_nxt = '0;
            w_sec_nxt   = L_GREENMAIN;
          end
`ifdef TRAFFIC_NIGHT_FLASH_EN
          ST_FLASH: begin
            // Leave night mode through the clearance of the last phase.
            w_state_nxt = ST_ALLRED;
            w_phase_nxt = LAST_PHASE;
            w_sec_nxt   = L_ALLRED;
          end
`endif
          default: begin
            w_state_nxt = ST_RESET;
            w_phase_nxt = '0;
            w_sec_nxt   = L_RESET;
          end
        endcase
      end
    end else begin
      w_sec_nxt = r_sec;
    end
  end

  // Pedestrian request: cleared when WALK starts (that cycle's press is lost).
  always_comb begin
    w_req_nxt = r_req;
    if (w_walk_go) begin
      w_req_nxt = 1'b0;
    end else if (!r_sync2 && (r_state != ST_WALK) && (r_state != ST_WALKFLASH)) begin
      w_req_nxt = 1'b1;
    end else begin
      w_req_nxt = r_req;
    end
  end

  // Lamp decode from the state registers.
  always_comb begin
    phase_lights = {N_PHASES{RED}};
    for (int i = 0; i < N_PHASES; i++) begin
      case (r_state)
        ST_GREEN:  phase_lights[3*i +: 3] = (r_phase == PW'(i)) ? GREEN : RED;
        ST_YELLOW: phase_lights[3*i +: 3] = (r_phase == PW'(i)) ? YELLOW : RED;
`ifdef TRAFFIC_NIGHT_FLASH_EN
        ST_FLASH:  phase_lights[3*i +: 3] = (i == 0) ? (w_half ? YELLOW : LAMP_OFF)
                                                      : (w_half ? RED : LAMP_OFF);
`endif
        default:   phase_lights[3*i +: 3] = RED;
      endcase
    end
    case (r_state)
      ST_WALK:      pea_lights = PEA_GREEN;
      ST_WALKFLASH: pea_lights = {1'b0, w_half};
`ifdef TRAFFIC_NIGHT_FLASH_EN
      ST_FLASH:     pea_lights = PEA_OFF;
`endif
      default:      pea_lights = PEA_RED;
    endcase
  end

  assign sol_light = r_req;
  assign sec_left  = r_sec;

endmodule
